// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: definitions shared by the multiply job sequencer files.
//   default_dp_width : default operand width, matches the multiplier's dp_width
//   seq_state_t      : sequencer FSM state encoding
package seq_mult_pkg;

    localparam int unsigned default_dp_width = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mult_job_sequencer_if.sv
// mult_job_sequencer_if: handshake bundle around the job sequencer.
//   in_*   : operand-pair valid/ready port from the producer
//   mult_* : Start/operand outputs to, and Ready/Product inputs from, the multiplier
//   out_*  : product valid/ready port to the consumer
// slave is the sequencer's view; master is the surrounding environment's view.
interface mult_job_sequencer_if #(
    parameter int unsigned dp_width = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [dp_width-1:0]   in_multiplicand;
    logic [dp_width-1:0]   in_multiplier;
    logic                  mult_start;
    logic [dp_width-1:0]   mult_multiplicand;
    logic [dp_width-1:0]   mult_multiplier;
    logic                  mult_ready;
    logic [2*dp_width-1:0] mult_product;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*dp_width-1:0] out_product;

    modport slave (
        input  in_valid, in_multiplicand, in_multiplier, mult_ready, mult_product, out_ready,
        output in_ready, mult_start, mult_multiplicand, mult_multiplier, out_valid, out_product
    );

    modport master (
        output in_valid, in_multiplicand, in_multiplier, mult_ready, mult_product, out_ready,
        input  in_ready, mult_start, mult_multiplicand, mult_multiplier, out_valid, out_product
    );
endinterface

// File: rtl/mult_operand_fifo.sv
// mult_operand_fifo: synchronous FIFO holding packed operand pairs.
//   clock, reset : rising-edge clock, synchronous active-high reset (empties FIFO)
//   push, pop    : write / read requests; ignored when full / empty
//   push_data    : word written on push
//   full, empty  : status derived from the registered pointers only
//   head         : oldest word, valid while !empty
module mult_operand_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] head
);
    localparam int unsigned aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw:0]      wr_ptr;
    logic [aw:0]      rd_ptr;

    // The extra MSB on each pointer tells full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign head  = mem[rd_ptr[aw-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[aw-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: feeds operand pairs to a sequential multiplier one job at a time.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : in_* producer port (in_ready = !full), mult_* multiplier
//                  handshake (one-cycle registered Start, held operands),
//                  out_* registered product port
// Results leave in push order; at most one job is in flight.
module mult_job_sequencer
    import seq_mult_pkg::*;
#(
    parameter int unsigned dp_width   = default_dp_width,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    mult_job_sequencer_if.slave  bus
);
    seq_state_t            state;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  capture;
    logic [2*dp_width-1:0] fifo_head;
    logic                  start_q;
    logic [dp_width-1:0]   mcand_q;
    logic [dp_width-1:0]   mplier_q;
    logic                  out_valid_q;
    logic [2*dp_width-1:0] out_product_q;

    mult_operand_fifo #(
        .width (2*dp_width),
        .depth (fifo_depth)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.in_valid),
        .pop       (fifo_pop),
        .push_data ({bus.in_multiplicand, bus.in_multiplier}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign fifo_pop = (state == IDLE) && !fifo_empty && bus.mult_ready;
    // Stalling in WAIT_DONE is lossless: the idle multiplier holds Product.
    assign capture  = (state == WAIT_DONE) && bus.mult_ready && (!out_valid_q || bus.out_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        {mcand_q, mplier_q} <= fifo_head;
                        start_q             <= 1'b1;
                        state               <= ISSUE;
                    end
                end
                ISSUE:     state <= WAIT_BUSY;
                WAIT_BUSY: if (!bus.mult_ready) state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (capture) begin
                        out_product_q <= bus.mult_product;
                        state         <= IDLE;
                    end
                end
                default:   state <= IDLE;
            endcase
            // A capture in the same cycle as consumption keeps out_valid set.
            if (capture) begin
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready          = !fifo_full;
    assign bus.mult_start        = start_q;
    assign bus.mult_multiplicand = mcand_q;
    assign bus.mult_multiplier   = mplier_q;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_product       = out_product_q;
endmodule

// File: tb/tb_mult_job_sequencer.sv
// tb_mult_job_sequencer: directed and random checks of mult_job_sequencer with a
// behavioural sequential multiplier and a push-order product scoreboard.
module tb_mult_job_sequencer;
    logic clock;
    logic reset;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_out   = 0;

    logic [7:0] exp_q [$];
    logic       prev_start;

    mult_job_sequencer_if #(.dp_width(4)) bus ();

    mult_job_sequencer #(
        .dp_width   (4),
        .fifo_depth (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural multiplier: Ready drops the edge after Start, rises after a
    // random number of cycles with the product of the operands it sees then.
    logic       m_busy;
    int         m_cnt;
    logic [7:0] m_prod;

    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_prod <= 8'd0;
        end else if (!m_busy) begin
            if (bus.mult_start) begin
                m_busy <= 1'b1;
                m_cnt  <= int'($urandom_range(1, 6));
            end
        end else if (m_cnt == 0) begin
            m_busy <= 1'b0;
            m_prod <= {4'b0, bus.mult_multiplicand} * {4'b0, bus.mult_multiplier};
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign bus.mult_ready   = !m_busy;
    assign bus.mult_product = m_prod;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clock) begin
        logic [7:0] p;
        if (reset) begin
            exp_q.delete();
            prev_start = 1'b0;
        end else begin
            if (bus.mult_start) begin
                check("start_single_cycle", 32'(prev_start), 32'd0);
                check("start_when_busy", 32'(bus.mult_ready), 32'd1);
                n_start++;
            end
            prev_start = bus.mult_start;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", 32'd1, 32'd0);
                else check("product_order", 32'(bus.out_product), 32'(exp_q.pop_front()));
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                p = {4'b0, bus.in_multiplicand} * {4'b0, bus.in_multiplier};
                exp_q.push_back(p);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        bus.in_valid        = 1'b1;
        bus.in_multiplicand = a;
        bus.in_multiplier   = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                tick();
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out_valid(input string tag);
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (bus.out_valid) return;
        end
        check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_mult_ready(input logic level, input string tag);
        for (int k = 0; k < 200; k++) begin
            if (bus.mult_ready === level) return;
            tick();
        end
        check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_n_out(input int target, input string tag);
        for (int k = 0; k < 500; k++) begin
            if (n_out >= target) return;
            tick();
        end
        check(tag, 32'(n_out), 32'(target));
    endtask

    initial begin
        int base_out;
        int base_start;

        reset               = 1'b1;
        bus.in_valid        = 1'b0;
        bus.in_multiplicand = 4'd0;
        bus.in_multiplier   = 4'd0;
        bus.out_ready       = 1'b0;

        // Reset state
        @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_product", 32'(bus.out_product), 32'd0);
        check("rst_mult_start", 32'(bus.mult_start), 32'd0);
        check("rst_operands", 32'({bus.mult_multiplicand, bus.mult_multiplier}), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single job: 8 x 9
        bus.out_ready = 1'b1;
        base_out   = n_out;
        base_start = n_start;
        push(4'd8, 4'd9);
        wait_out_valid("single_timeout");
        check("single_product", 32'(bus.out_product), 32'd72);
        repeat (5) tick();
        check("single_out_count", 32'(n_out - base_out), 32'd1);
        check("single_start_count", 32'(n_start - base_start), 32'd1);
        check("single_out_valid_clear", 32'(bus.out_valid), 32'd0);

        // Back-to-back stream
        base_out = n_out;
        push(4'd15, 4'd15);
        push(4'd0, 4'd13);
        push(4'd1, 4'd1);
        push(4'd7, 4'd6);
        wait_n_out(base_out + 4, "stream_timeout");

        // FIFO full: one in flight, four buffered
        tick();
        bus.out_ready = 1'b0;
        base_out = n_out;
        push(4'd2, 4'd3);
        push(4'd4, 4'd5);
        push(4'd6, 4'd7);
        push(4'd8, 4'd9);
        push(4'd10, 4'd11);
        bus.in_valid        = 1'b1;
        bus.in_multiplicand = 4'd15;
        bus.in_multiplier   = 4'd14;
        @(negedge clock);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        wait_out_valid("full_first_timeout");
        check("full_first_product", 32'(bus.out_product), 32'd6);
        repeat (10) tick();
        check("full_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        wait_n_out(base_out + 5, "full_drain_timeout");
        repeat (3) tick();
        check("full_drain_count", 32'(n_out - base_out), 32'd5);

        // Output stall for 20 cycles with a second job complete
        bus.out_ready = 1'b0;
        base_out = n_out;
        push(4'd3, 4'd5);
        push(4'd6, 4'd7);
        wait_out_valid("stall_first_timeout");
        check("stall_first", 32'(bus.out_product), 32'd15);
        repeat (20) tick();
        @(negedge clock);
        check("stall_hold_product", 32'(bus.out_product), 32'd15);
        check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        check("stall_mult_idle", 32'(bus.mult_ready), 32'd1);
        tick();
        bus.out_ready = 1'b1;
        tick();
        check("stall_second", 32'(bus.out_product), 32'd42);
        check("stall_second_valid", 32'(bus.out_valid), 32'd1);
        wait_n_out(base_out + 2, "stall_drain_timeout");

        // Capture and drain on the cycle Ready rises
        tick();
        bus.out_ready = 1'b0;
        push(4'd9, 4'd9);
        push(4'd2, 4'd11);
        wait_out_valid("simul_first_timeout");
        check("simul_first", 32'(bus.out_product), 32'd81);
        wait_mult_ready(1'b0, "simul_busy_timeout");
        wait_mult_ready(1'b1, "simul_done_timeout");
        bus.out_ready = 1'b1;
        tick();
        check("simul_valid_stays", 32'(bus.out_valid), 32'd1);
        check("simul_second", 32'(bus.out_product), 32'd22);
        repeat (3) tick();

        // Reset in WAIT_DONE with two jobs buffered
        bus.out_ready = 1'b0;
        push(4'd1, 4'd2);
        push(4'd3, 4'd4);
        push(4'd5, 4'd6);
        push(4'd7, 4'd8);
        wait_out_valid("rstmid_first_timeout");
        wait_mult_ready(1'b0, "rstmid_busy_timeout");
        wait_mult_ready(1'b1, "rstmid_done_timeout");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
        check("rstmid_out_product", 32'(bus.out_product), 32'd0);
        base_start = n_start;
        repeat (20) tick();
        check("rstmid_no_start", 32'(n_start - base_start), 32'd0);

        // Random traffic against the scoreboard
        base_out = n_out;
        for (int c = 0; c < 400; c++) begin
            bus.in_valid        = ($urandom_range(0, 2) != 0);
            bus.in_multiplicand = 4'($urandom);
            bus.in_multiplier   = 4'($urandom);
            bus.out_ready       = ($urandom_range(0, 1) == 1);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) tick();
        check("random_drained", 32'(exp_q.size()), 32'd0);
        check("random_progress", 32'(n_out > base_out + 10), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_job_sequencer.md
# mult_job_sequencer

Upstream job feeder for `Sequential_Binary_Multiplier`.
- Accepts operand pairs through a valid/ready port and buffers them in a small FIFO.
- Issues one-cycle `Start` pulses to the multiplier and tracks its `Ready` handshake.
- Captures each `Product` into an output register presented on a valid/ready port.
- Lets producers stream multiply jobs without knowing the multiplier's iteration latency.

## Interface
Parameters:
- `dp_width`, 4, operand width; must match the multiplier's `dp_width`.
- `fifo_depth`, 4, operand FIFO entries; power of two, ≥2.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer offers an operand pair.
- `in_ready`  out  1  FIFO can accept a pair; equals !full.
- `in_multiplicand`  in  dp_width  multiplicand.
- `in_multiplier`  in  dp_width  multiplier.
- `mult_start`  out  1  to multiplier `Start`; registered one-cycle pulse.
- `mult_multiplicand`  out  dp_width  to multiplier `Multiplicand`; registered.
- `mult_multiplier`  out  dp_width  to multiplier `Multiplier`; registered.
- `mult_ready`  in  1  from multiplier `Ready`; high when the multiplier is idle.
- `mult_product`  in  2*dp_width  from multiplier `Product`.
- `out_valid`  out  1  `out_product` holds an unconsumed result.
- `out_ready`  in  1  consumer accepts the result.
- `out_product`  out  2*dp_width  captured product.

## Operation
Push:
- A push occurs when `in_valid && in_ready`.
- `in_ready` depends only on the registered full flag.
- A pop in the same cycle does not raise `in_ready` for that cycle.

FSM states:
- **IDLE**
  - If the FIFO is not empty and `mult_ready` is 1: pop the head into the `mult_multiplicand`/`mult_multiplier` registers and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `mult_start` = 1 for exactly this cycle.
  - Operand registers hold the popped pair.
  - Go to WAIT_BUSY unconditionally.
- **WAIT_BUSY**
  - Go to WAIT_DONE when `mult_ready` = 0.
- **WAIT_DONE**
  - Capture condition: `mult_ready` = 1 and (`out_valid` = 0 or `out_ready` = 1).
  - On capture: load `mult_product` into `out_product`, set `out_valid`, go to IDLE.
  - While the capture condition is false, stay in WAIT_DONE. The multiplier holds `Product` stable while idle with `Start` low, so stalling here is lossless.

Output register:
- `out_valid` clears on `out_valid && out_ready` unless a capture occurs in the same cycle; capture wins and `out_valid` stays 1.
- `out_product` holds its value after consumption.

Arithmetic and ordering:
- No arithmetic in this block; the product is passed through at full 2*dp_width bits.
- Results leave in push order; at most one job is in flight.

Operand registers:
- They keep their value after ISSUE, so the multiplier inputs stay stable through the computation.

## Timing
Reset values (synchronous, the cycle `reset` is sampled high):
- FSM state: IDLE.
- FIFO: empty (`in_ready` = 1 after reset).
- `mult_start` = 0.
- Operand registers = 0.
- `out_valid` = 0 and `out_product` = 0.

Latency, from a push into an empty FIFO at edge 0 with the multiplier idle:
- Pop at edge 1.
- `mult_start` high during cycle 2; multiplier loads at edge 2.
- Capture occurs at the first edge where `mult_ready` is back to 1; `out_valid` is high the cycle after.

Boundary conditions:
- **FIFO full:** `in_ready` = 0; pushes are ignored.
- **FIFO empty:** no issue. Pointers carry an extra wrap bit, and full/empty are distinguished on wrap-around.
- **Reset mid-operation:** the FSM returns to IDLE and buffered or in-flight jobs are dropped. The multiplier is reset by the same top-level reset (`reset_b` = ~`reset`). If the multiplier is still busy anyway, IDLE waits for `mult_ready` = 1 before issuing, and the stale result is never captured.
- **`mult_ready` stuck high after ISSUE:** the FSM waits in WAIT_BUSY; there is no timeout.

## Structure
Shared package `seq_mult_pkg`:
- FSM state encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3.
- Default `dp_width`.

Sub-module `mult_operand_fifo`:
- Synchronous FIFO of 2*dp_width-bit words.
- Ports: push, pop, full, empty, head data.
- The sequencer FSM and output register live in `mult_job_sequencer`.

## Test plan
Every scenario runs with `mult_job_sequencer` connected to `Sequential_Binary_Multiplier`, `dp_width` = 4.
1. **Single job:** push 4'b1000 × 4'b1001 with `out_ready` = 1 → exactly one `out_valid` pulse with `out_product` = 8'd72; `mult_start` high for exactly one cycle.
2. **Back-to-back stream:** push (15,15), (0,13), (1,1), (7,6) continuously → outputs 225, 0, 1, 42 in that order; no `mult_start` while `mult_ready` = 0.
3. **FIFO full:** hold `out_ready` = 0 and push 6 pairs → after 5 accepted pushes (1 in flight, 4 buffered), `in_ready` = 0 and the 6th push is not accepted. `out_valid` = 1 holding the first product. After `out_ready` is raised, all 5 results drain in order.
4. **Output stall:** `out_ready` = 0 for 20 cycles while a second job completes → FSM stays in WAIT_DONE; `out_product` keeps the first result until it is consumed, then the second result appears with no loss.
5. **Simultaneous capture and drain:** `out_ready` = 1 on the cycle `mult_ready` rises with `out_valid` = 1 → the old result is consumed, the new one is captured, and `out_valid` stays 1.
6. **Reset mid-operation:** assert `reset` for one cycle during WAIT_DONE with 2 jobs buffered → `out_valid` = 0, `in_ready` = 1, no further `mult_start` until a new push arrives.
